tx_fcs_pad: RTL and testbench



---
 rtl/tx_fcs_pad_pkg.sv | 39 +++
 rtl/tx_fcs_pad_crc32_byte.sv | 24 ++
 rtl/tx_fcs_pad.sv | 156 +++++++++++++++
 tb/tb_tx_fcs_pad.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_fcs_pad_pkg.sv
// tx_fcs_pad_pkg
//   Shared definitions for the transmit framing path:
//   - 2-bit byte codes carried alongside every stream byte
//   - IEEE 802.3 CRC-32 constants (reflected form)
//   - framer state encoding and byte-count width
//   - fcs_byte(): selects one transmitted FCS byte from the running CRC
package tx_fcs_pad_pkg;

  localparam logic [1:0] PCC_DATA   = 2'b00;
  localparam logic [1:0] PCC_SOP    = 2'b01;
  localparam logic [1:0] PCC_EOP    = 2'b10;
  localparam logic [1:0] PCC_BADEOP = 2'b11;

  localparam logic [31:0] CRC32_POLY_R = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

  localparam int unsigned CNT_W   = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAD  = 2'd2,
    ST_FCS  = 2'd3
  } state_e;

  // The FCS is the complemented CRC, sent least-significant byte first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    fcs = ~crc;
    case (idx)
      2'd0:    return fcs[7:0];
      2'd1:    return fcs[15:8];
      2'd2:    return fcs[23:16];
      default: return fcs[31:24];
    endcase
  endfunction

endpackage

// File: rtl/tx_fcs_pad_crc32_byte.sv
// crc32_byte
//   Combinational one-byte step of the reflected IEEE 802.3 CRC-32.
//   Data bits are consumed LSB first. Shared with the receive-side checker.
//   Ports:
//     crc_in  [31:0]  running CRC before this byte
//     data    [7:0]   byte to fold in
//     crc_out [31:0]  running CRC after this byte
module crc32_byte
  import tx_fcs_pad_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) crc_out = (crc_out >> 1) ^ CRC32_POLY_R;
      else                      crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/tx_fcs_pad.sv
// tx_fcs_pad
//   Transmit framing stage: forwards a coded byte stream, pads short frames
//   up to min_frame bytes with pad_byte, and appends the CRC-32 FCS.
//   Output is a single registered entry; 1 byte/clk when downstream is ready.
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     c_srdy/c_code/c_data  upstream byte, c_drdy = byte accepted this cycle
//     p_srdy/p_code/p_data  registered downstream byte, p_drdy = taken
module tx_fcs_pad
  import tx_fcs_pad_pkg::*;
#(
  parameter int unsigned min_frame = 60,
  parameter logic [7:0]  pad_byte  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c_srdy,
  input  logic [1:0] c_code,
  input  logic [7:0] c_data,
  output logic       c_drdy,
  output logic       p_srdy,
  output logic [1:0] p_code,
  output logic [7:0] p_data,
  input  logic       p_drdy
);

  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(min_frame);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0]       crc_q, crc_d, crc_next;
  logic [1:0]        fcs_idx_q, fcs_idx_d;
  logic              p_srdy_q, p_srdy_d;
  logic [1:0]        p_code_q, p_code_d;
  logic [7:0]        p_data_q, p_data_d;
  logic [7:0]        crc_data;
  logic              load, accept, pad_short;

  // The output register can take a new byte when empty or being drained now.
  assign load      = ~p_srdy_q | p_drdy;
  assign c_drdy    = ((state_q == ST_IDLE) | (state_q == ST_DATA)) & load;
  assign accept    = c_srdy & c_drdy;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  // Strict compare: a frame exactly min_frame long is not padded.
  assign pad_short = cnt_inc < MIN_LEN;
  assign crc_data  = (state_q == ST_PAD) ? pad_byte : c_data;

  // crc_q sits at CRC32_INIT in IDLE, so the SOP byte starts a fresh CRC.
  crc32_byte u_crc (
    .crc_in (crc_q),
    .data   (crc_data),
    .crc_out(crc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      crc_q     <= CRC32_INIT;
      fcs_idx_q <= '0;
      p_srdy_q  <= 1'b0;
      p_code_q  <= '0;
      p_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      fcs_idx_q <= fcs_idx_d;
      p_srdy_q  <= p_srdy_d;
      p_code_q  <= p_code_d;
      p_data_q  <= p_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && c_code == PCC_SOP) state_d = ST_DATA;
      ST_DATA: begin
        if (accept) begin
          if (c_code == PCC_EOP)         state_d = pad_short ? ST_PAD : ST_FCS;
          else if (c_code == PCC_BADEOP) state_d = ST_IDLE;
        end
      end
      ST_PAD:  if (load && !pad_short) state_d = ST_FCS;
      ST_FCS:  if (load && fcs_idx_q == 2'd3) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    fcs_idx_d = fcs_idx_q;
    p_srdy_d  = p_srdy_q;
    p_code_d  = p_code_q;
    p_data_d  = p_data_q;
    if (load) p_srdy_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Non-SOP bytes outside a frame are accepted and dropped.
        if (accept && c_code == PCC_SOP) begin
          p_srdy_d = 1'b1;
          p_code_d = PCC_SOP;
          p_data_d = c_data;
          cnt_d    = 11'd1;
          crc_d    = crc_next;
        end
      end
      ST_DATA: begin
        if (accept) begin
          p_srdy_d = 1'b1;
          p_data_d = c_data;
          if (c_code == PCC_BADEOP) begin
            // Aborted frame: no pad, no FCS, framer rearmed.
            p_code_d = PCC_BADEOP;
            cnt_d    = '0;
            crc_d    = CRC32_INIT;
          end else begin
            // A stray SOP mid-frame is carried as ordinary data.
            p_code_d = PCC_DATA;
            cnt_d    = cnt_inc;
            crc_d    = crc_next;
          end
        end
      end
      ST_PAD: begin
        if (load) begin
          p_srdy_d = 1'b1;
          p_code_d = PCC_DATA;
          p_data_d = pad_byte;
          cnt_d    = cnt_inc;
          crc_d    = crc_next;
        end
      end
      ST_FCS: begin
        if (load) begin
          p_srdy_d  = 1'b1;
          p_code_d  = (fcs_idx_q == 2'd3) ? PCC_EOP : PCC_DATA;
          p_data_d  = fcs_byte(crc_q, fcs_idx_q);
          fcs_idx_d = fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            cnt_d = '0;
            crc_d = CRC32_INIT;
          end
        end
      end
      default: ;
    endcase
  end

  assign p_srdy = p_srdy_q;
  assign p_code = p_code_q;
  assign p_data = p_data_q;

endmodule

// File: tb/tb_tx_fcs_pad.sv
// tb_tx_fcs_pad
//   Two framers: dut_a with padding disabled, dut_b with default padding.
//   Expected output frames come from a frame-level model (pad, CRC, FCS)
//   pushed into per-DUT queues; one compare process per DUT pops a byte for
//   every downstream transfer.
module tb_tx_fcs_pad;

  localparam logic [1:0]  C_DATA = 2'b00;
  localparam logic [1:0]  C_SOP  = 2'b01;
  localparam logic [1:0]  C_EOP  = 2'b10;
  localparam logic [1:0]  C_BAD  = 2'b11;
  localparam logic [31:0] POLY   = 32'hEDB88320;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic p_drdy = 1'b1;
  bit   rnd = 1'b0;

  logic       c_srdy_a = 1'b0, c_srdy_b = 1'b0;
  logic [1:0] c_code_a = '0,   c_code_b = '0;
  logic [7:0] c_data_a = '0,   c_data_b = '0;
  logic       c_drdy_a, c_drdy_b, p_srdy_a, p_srdy_b;
  logic [1:0] p_code_a, p_code_b;
  logic [7:0] p_data_a, p_data_b;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  logic [9:0] last_exp[$];
  logic [7:0] q[$];
  int zero_cycles;

  always #5 clk = ~clk;

  tx_fcs_pad #(.min_frame(0), .pad_byte(8'h00)) dut_a (
    .clk(clk), .reset(reset),
    .c_srdy(c_srdy_a), .c_code(c_code_a), .c_data(c_data_a), .c_drdy(c_drdy_a),
    .p_srdy(p_srdy_a), .p_code(p_code_a), .p_data(p_data_a), .p_drdy(p_drdy)
  );

  tx_fcs_pad dut_b (
    .clk(clk), .reset(reset),
    .c_srdy(c_srdy_b), .c_code(c_code_b), .c_data(c_data_b), .c_drdy(c_drdy_b),
    .p_srdy(p_srdy_b), .p_code(p_code_b), .p_data(p_data_b), .p_drdy(p_drdy)
  );

  always @(posedge clk) begin
    #1;
    p_drdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Expected downstream frame for one input frame.
  task automatic model_push(input bit u, input logic [7:0] b[$], input bit bad, input int mf);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    int n;
    last_exp.delete();
    body = b;
    n = b.size();
    if (bad) begin
      for (int i = 0; i < n; i++)
        last_exp.push_back({(i == 0) ? C_SOP : ((i == n - 1) ? C_BAD : C_DATA), b[i]});
    end else begin
      while (body.size() < mf) body.push_back(8'h00);
      fcs = ~ref_crc(body);
      for (int i = 0; i < body.size(); i++)
        last_exp.push_back({(i == 0) ? C_SOP : C_DATA, body[i]});
      for (int k = 0; k < 4; k++)
        last_exp.push_back({(k == 3) ? C_EOP : C_DATA, fcs[8*k +: 8]});
    end
    foreach (last_exp[i]) begin
      if (u) exp_b.push_back(last_exp[i]);
      else   exp_a.push_back(last_exp[i]);
    end
  endtask

  task automatic gen(input int len, output logic [7:0] o[$]);
    o.delete();
    for (int i = 0; i < len; i++) o.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_byte(input bit u, input logic [1:0] code, input logic [7:0] data);
    int n;
    bit go;
    n = 0;
    if (u) begin c_srdy_b = 1'b1; c_code_b = code; c_data_b = data; end
    else   begin c_srdy_a = 1'b1; c_code_a = code; c_data_a = data; end
    forever begin
      @(negedge clk);
      go = u ? c_drdy_b : c_drdy_a;
      @(posedge clk);
      #1;
      if (go) break;
      n++;
      if (n > 1000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout dut=%0d actual=stalled required=accepted", u);
        break;
      end
    end
  endtask

  task automatic idle_in(input bit u);
    if (u) c_srdy_b = 1'b0;
    else   c_srdy_a = 1'b0;
  endtask

  task automatic send_frame(input bit u, input logic [7:0] b[$], input bit bad);
    int n;
    n = b.size();
    for (int i = 0; i < n; i++)
      send_byte(u, (i == 0) ? C_SOP : ((i == n - 1) ? (bad ? C_BAD : C_EOP) : C_DATA), b[i]);
    idle_in(u);
  endtask

  task automatic wait_drain(input bit u);
    int n;
    n = 0;
    while ((u ? exp_b.size() : exp_a.size()) != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(u ? "drain_b" : "drain_a", u ? exp_b.size() : exp_a.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (!reset && p_srdy_a && p_drdy) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected actual=%h required=no_byte", {p_code_a, p_data_a});
      end else begin
        e = exp_a.pop_front();
        check("a_byte", {22'h0, p_code_a, p_data_a}, {22'h0, e});
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (!reset && p_srdy_b && p_drdy) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected actual=%h required=no_byte", {p_code_b, p_data_b});
      end else begin
        e = exp_b.pop_front();
        check("b_byte", {22'h0, p_code_b, p_data_b}, {22'h0, e});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_p_srdy", p_srdy_b, 0);
    check("rst_p_code", p_code_b, 0);
    check("rst_p_data", p_data_b, 0);
    reset = 1'b0;
    #1;
    check("rst_c_drdy_a", c_drdy_a, 1);
    check("rst_c_drdy_b", c_drdy_b, 1);
    check("rst_p_srdy_a", p_srdy_a, 0);

    // "123456789" without padding: known CRC 0xCBF43926.
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_crc", ~ref_crc(q), 32'hCBF43926);
    model_push(1'b0, q, 1'b0, 0);
    check("model_len9", last_exp.size(), 13);
    check("model_fcs0", last_exp[9],  {C_DATA, 8'h26});
    check("model_fcs1", last_exp[10], {C_DATA, 8'h39});
    check("model_fcs2", last_exp[11], {C_DATA, 8'hF4});
    check("model_fcs3", last_exp[12], {C_EOP,  8'hCB});
    send_frame(1'b0, q, 1'b0);
    wait_drain(1'b0);

    // 10-byte frame padded to 60 plus FCS; input stalled for 54 cycles.
    gen(10, q);
    model_push(1'b1, q, 1'b0, 60);
    check("model_len10", last_exp.size(), 64);
    send_frame(1'b1, q, 1'b0);
    zero_cycles = 0;
    forever begin
      @(negedge clk);
      if (c_drdy_b || zero_cycles > 500) break;
      zero_cycles++;
    end
    check("pad_fcs_stall", zero_cycles, 54);
    wait_drain(1'b1);

    // Length boundary: 60 needs no pad, 61 neither.
    gen(60, q);
    model_push(1'b1, q, 1'b0, 60);
    check("model_len60", last_exp.size(), 64);
    send_frame(1'b1, q, 1'b0);
    gen(61, q);
    model_push(1'b1, q, 1'b0, 60);
    check("model_len61", last_exp.size(), 65);
    send_frame(1'b1, q, 1'b0);
    wait_drain(1'b1);

    // Back-to-back 100-byte frames, first unstalled then with random p_drdy.
    for (int pass = 0; pass < 2; pass++) begin
      rnd = (pass == 1);
      for (int f = 0; f < 5; f++) begin
        gen(100, q);
        model_push(1'b1, q, 1'b0, 60);
        send_frame(1'b1, q, 1'b0);
      end
      wait_drain(1'b1);
    end

    // Random lengths on both framers under random backpressure.
    for (int f = 0; f < 6; f++) begin
      gen($urandom_range(2, 80), q);
      model_push(1'b1, q, 1'b0, 60);
      send_frame(1'b1, q, 1'b0);
      gen($urandom_range(2, 20), q);
      model_push(1'b0, q, 1'b0, 0);
      send_frame(1'b0, q, 1'b0);
    end
    wait_drain(1'b1);
    wait_drain(1'b0);
    rnd = 1'b0;

    // Stray bytes in IDLE, aborted frame, then a clean frame.
    send_byte(1'b1, C_DATA, 8'hA5);
    send_byte(1'b1, C_EOP, 8'h5A);
    send_byte(1'b1, C_BAD, 8'h11);
    idle_in(1'b1);
    gen(20, q);
    model_push(1'b1, q, 1'b1, 60);
    send_frame(1'b1, q, 1'b1);
    gen(64, q);
    model_push(1'b1, q, 1'b0, 60);
    send_frame(1'b1, q, 1'b0);
    wait_drain(1'b1);

    // Reset while the second FCS byte is on the output.
    gen(60, q);
    model_push(1'b1, q, 1'b0, 60);
    send_frame(1'b1, q, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("fcs1_data", p_data_b, {24'h0, last_exp[61][7:0]});
    check("fcs1_code", p_code_b, {30'h0, last_exp[61][9:8]});
    reset = 1'b1;
    #1;
    check("async_rst_p_srdy", p_srdy_b, 0);
    exp_b.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("post_rst_c_drdy", c_drdy_b, 1);
    gen(12, q);
    model_push(1'b1, q, 1'b0, 60);
    send_frame(1'b1, q, 1'b0);
    wait_drain(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
